// File: rtl/mac_arb_pkg.sv
// Shared types and helpers for the MAC frame arbiter and its round-robin picker.
package mac_arb_pkg;

    // Arbiter phases: waiting for a requester, streaming a frame, draining the result.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2
    } arb_state_t;

    // Width of a requester index; never less than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr+1, wrapping modulo NREQ.
module rr_pick
    import mac_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    // Scan NREQ positions starting just after the last-served requester.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any     = 1'b1;
                gnt_idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/mac_frame_arbiter.sv
// Round-robin frame scheduler sharing one fixed_mac between NREQ operand requesters.
// A grant lasts a whole frame; the accumulated result is returned tagged with id and beat count.
module mac_frame_arbiter
    import mac_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int WA   = 12,
    parameter  int WB   = 8,
    parameter  int WO   = 45,
    parameter  int WCNT = 16,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*WA-1:0] req_a,
    input  logic [NREQ*WB-1:0] req_b,
    input  logic [NREQ-1:0]    req_last,
    output logic [WA-1:0]      mac_a_data,
    output logic [WB-1:0]      mac_b_data,
    output logic               mac_a_valid,
    output logic               mac_b_valid,
    input  logic               mac_a_ready,
    input  logic               mac_b_ready,
    output logic               mac_a_last,
    output logic               mac_b_last,
    input  logic [WO-1:0]      mac_out_data,
    input  logic               mac_out_valid,
    output logic               mac_out_ready,
    input  logic               mac_overflow,
    input  logic               mac_underflow,
    output logic [WO-1:0]      res_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic [WCNT-1:0]    res_beats,
    output logic               res_overflow,
    output logic               res_underflow,
    output logic               busy
);

    arb_state_t      state, state_next;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  ptr;
    logic [WCNT-1:0] beats;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            beat_acc;
    logic            res_hs;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign beat_acc = (state == STREAM) && req_valid[grant] && mac_a_ready && mac_b_ready;
    assign res_hs   = (state == WAIT_RES) && mac_out_valid && res_ready;
    assign busy     = (state != IDLE);

    // Both MAC channels carry the same beat, so their handshake sidebands are identical.
    assign mac_b_valid = mac_a_valid;
    assign mac_b_last  = mac_a_last;

    // State, grant, rotation pointer and saturating beat counter.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= IDW'(NREQ - 1);
            beats <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && pick_any) begin
                grant <= pick_idx;
                beats <= '0;
            end
            if (beat_acc && beats != '1) begin
                beats <= beats + 1'b1;
            end
            if (res_hs) begin
                ptr <= grant;
            end
        end
    end

    // Next-state decode plus the operand and result muxes for the current phase.
    always_comb begin
        state_next    = state;
        req_ready     = '0;
        mac_a_valid   = 1'b0;
        mac_a_last    = 1'b0;
        mac_a_data    = '0;
        mac_b_data    = '0;
        mac_out_ready = 1'b0;
        res_valid     = 1'b0;
        res_data      = '0;
        res_id        = '0;
        res_beats     = '0;
        res_overflow  = 1'b0;
        res_underflow = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                mac_a_valid      = req_valid[grant];
                mac_a_last       = req_last[grant];
                mac_a_data       = req_a[int'(grant)*WA +: WA];
                mac_b_data       = req_b[int'(grant)*WB +: WB];
                req_ready[grant] = mac_a_ready & mac_b_ready;
                if (beat_acc && req_last[grant]) begin
                    state_next = WAIT_RES;
                end
            end
            WAIT_RES: begin
                mac_out_ready = res_ready;
                res_valid     = mac_out_valid;
                res_data      = mac_out_data;
                res_overflow  = mac_overflow;
                res_underflow = mac_underflow;
                res_id        = grant;
                res_beats     = beats;
                if (res_hs) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mac_frame_arbiter.sv
// Randomized bench for mac_frame_arbiter: requester frames, a stub MAC that sums A*B,
// and a frame-level round-robin reference with a result scoreboard.
module tb_mac_frame_arbiter;

    localparam int NREQ   = 4;
    localparam int WA     = 12;
    localparam int WB     = 8;
    localparam int WO     = 45;
    localparam int WCNT   = 4;
    localparam int IDW    = 2;
    localparam int CYCLES = 4000;
    localparam int SATMAX = (1 << WCNT) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*WA-1:0] req_a;
    logic [NREQ*WB-1:0] req_b;
    logic [NREQ-1:0]    req_last;
    logic [WA-1:0]      mac_a_data;
    logic [WB-1:0]      mac_b_data;
    logic               mac_a_valid, mac_b_valid;
    logic               mac_a_ready, mac_b_ready;
    logic               mac_a_last, mac_b_last;
    logic [WO-1:0]      mac_out_data;
    logic               mac_out_valid;
    logic               mac_out_ready;
    logic               mac_overflow, mac_underflow;
    logic [WO-1:0]      res_data;
    logic               res_valid;
    logic               res_ready;
    logic [IDW-1:0]     res_id;
    logic [WCNT-1:0]    res_beats;
    logic               res_overflow, res_underflow;
    logic               busy;

    mac_frame_arbiter #(
        .NREQ(NREQ), .WA(WA), .WB(WB), .WO(WO), .WCNT(WCNT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_last      (req_last),
        .mac_a_data    (mac_a_data),
        .mac_b_data    (mac_b_data),
        .mac_a_valid   (mac_a_valid),
        .mac_b_valid   (mac_b_valid),
        .mac_a_ready   (mac_a_ready),
        .mac_b_ready   (mac_b_ready),
        .mac_a_last    (mac_a_last),
        .mac_b_last    (mac_b_last),
        .mac_out_data  (mac_out_data),
        .mac_out_valid (mac_out_valid),
        .mac_out_ready (mac_out_ready),
        .mac_overflow  (mac_overflow),
        .mac_underflow (mac_underflow),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_id        (res_id),
        .res_beats     (res_beats),
        .res_overflow  (res_overflow),
        .res_underflow (res_underflow),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Requester-side frame generators.
    bit             r_pres [NREQ];
    int             r_left [NREQ];
    int             r_cnt  [NREQ];
    logic [63:0]    r_sum  [NREQ];
    logic [WA-1:0]  r_a    [NREQ];
    logic [WB-1:0]  r_b    [NREQ];

    typedef struct {
        int          id;
        int          beats;
        logic [63:0] sum;
    } exp_t;
    exp_t exp_q[$];

    // Frame-level view of the shared MAC.
    bit frame_open;
    bit waiting;
    int g;
    int last_served;
    int frames_done;

    // Stub MAC: sums A*B over a frame and presents it after a random delay.
    logic [63:0] mac_acc, mac_res;
    bit          mac_pend;
    int          mac_dly;
    bit          m_ovf, m_udf;

    function automatic int rr_expect(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_init();
        for (int i = 0; i < NREQ; i++) begin
            r_pres[i] = 1'b0;
            r_left[i] = 0;
            r_cnt[i]  = 0;
            r_sum[i]  = '0;
        end
        exp_q.delete();
        frame_open  = 1'b0;
        waiting     = 1'b0;
        last_served = NREQ - 1;
        mac_acc     = '0;
        mac_pend    = 1'b0;
        mac_dly     = 0;
    endtask

    task automatic drive_cycle();
        for (int i = 0; i < NREQ; i++) begin
            if (!r_pres[i]) begin
                if (r_left[i] == 0 && $urandom_range(3) == 0) begin
                    r_left[i] = $urandom_range(1, 20);
                    r_cnt[i]  = 0;
                    r_sum[i]  = '0;
                end
                if (r_left[i] > 0 && $urandom_range(3) != 0) begin
                    r_pres[i] = 1'b1;
                    r_a[i]    = WA'($urandom);
                    r_b[i]    = WB'($urandom);
                end
            end
            req_valid[i]        = r_pres[i];
            req_a[i*WA +: WA]   = r_pres[i] ? r_a[i] : WA'($urandom);
            req_b[i*WB +: WB]   = r_pres[i] ? r_b[i] : WB'($urandom);
            req_last[i]         = r_pres[i] ? (r_left[i] == 1) : 1'($urandom);
        end
        mac_a_ready = ($urandom_range(3) != 0);
        mac_b_ready = ($urandom_range(3) != 0);
        res_ready   = ($urandom_range(1) == 1);
        if (mac_pend && mac_dly > 0) mac_dly--;
        if (mac_pend && mac_dly == 0) begin
            mac_out_valid = 1'b1;
            mac_out_data  = mac_res[WO-1:0];
            mac_overflow  = m_ovf;
            mac_underflow = m_udf;
        end else begin
            // Stray results outside the drain phase must be ignored by the arbiter.
            mac_out_valid = !waiting && ($urandom_range(7) == 0);
            mac_out_data  = {13'($urandom), 32'($urandom)};
            mac_overflow  = 1'($urandom);
            mac_underflow = 1'($urandom);
        end
    endtask

    task automatic sample_cycle();
        exp_t e;
        logic [NREQ-1:0] exp_rdy;
        if (mac_a_valid && mac_a_ready && mac_b_ready) begin
            mac_acc = mac_acc + 64'(mac_a_data) * 64'(mac_b_data);
            if (mac_a_last) begin
                mac_res  = mac_acc;
                mac_acc  = '0;
                mac_pend = 1'b1;
                mac_dly  = $urandom_range(3);
                m_ovf    = 1'($urandom);
                m_udf    = 1'($urandom);
            end
        end
        if (!frame_open && !waiting) begin
            check("idle_busy", busy, 0);
            check("idle_req_ready", req_ready, 0);
            check("idle_mac_valid", {mac_a_valid, mac_b_valid}, 0);
            check("idle_out_ready", mac_out_ready, 0);
            check("idle_res_valid", res_valid, 0);
            if (|req_valid) begin
                g          = rr_expect(last_served, req_valid);
                frame_open = 1'b1;
            end
        end else if (frame_open) begin
            exp_rdy = (mac_a_ready && mac_b_ready) ? NREQ'(1 << g) : '0;
            check("stream_busy", busy, 1);
            check("stream_req_ready", req_ready, exp_rdy);
            check("stream_a_valid", mac_a_valid, req_valid[g]);
            check("stream_b_valid", mac_b_valid, req_valid[g]);
            check("stream_out_ready", mac_out_ready, 0);
            check("stream_res_valid", res_valid, 0);
            if (req_valid[g]) begin
                check("stream_a_data", mac_a_data, r_a[g]);
                check("stream_b_data", mac_b_data, r_b[g]);
                check("stream_a_last", mac_a_last, r_left[g] == 1);
                check("stream_b_last", mac_b_last, r_left[g] == 1);
                if (mac_a_ready && mac_b_ready) begin
                    r_pres[g] = 1'b0;
                    r_cnt[g]++;
                    r_sum[g]  = r_sum[g] + 64'(r_a[g]) * 64'(r_b[g]);
                    r_left[g]--;
                    if (r_left[g] == 0) begin
                        e.id    = g;
                        e.beats = (r_cnt[g] > SATMAX) ? SATMAX : r_cnt[g];
                        e.sum   = r_sum[g];
                        exp_q.push_back(e);
                        frame_open = 1'b0;
                        waiting    = 1'b1;
                    end
                end
            end
        end else begin
            check("wait_busy", busy, 1);
            check("wait_req_ready", req_ready, 0);
            check("wait_mac_valid", mac_a_valid, 0);
            check("wait_out_ready", mac_out_ready, res_ready);
            check("wait_res_valid", res_valid, mac_out_valid);
            if (mac_out_valid) begin
                e = exp_q[0];
                check("res_data", res_data, e.sum);
                check("res_id", res_id, e.id);
                check("res_beats", res_beats, e.beats);
                check("res_overflow", res_overflow, mac_overflow);
                check("res_underflow", res_underflow, mac_underflow);
                if (res_ready) begin
                    last_served = e.id;
                    void'(exp_q.pop_front());
                    waiting  = 1'b0;
                    mac_pend = 1'b0;
                    frames_done++;
                end
            end
        end
    endtask

    initial begin
        frames_done   = 0;
        reset         = 1'b1;
        req_valid     = '0;
        req_a         = '0;
        req_b         = '0;
        req_last      = '0;
        mac_a_ready   = 1'b0;
        mac_b_ready   = 1'b0;
        res_ready     = 1'b1;
        mac_out_valid = 1'b1;
        mac_out_data  = 45'h1234_5678;
        mac_overflow  = 1'b1;
        mac_underflow = 1'b1;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_mac_valid", {mac_a_valid, mac_b_valid, mac_a_last, mac_b_last}, 0);
        check("rst_mac_data", {mac_a_data, mac_b_data}, 0);
        check("rst_out_ready", mac_out_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_fields", {res_data, res_id, res_beats}, 0);
        check("rst_busy", busy, 0);

        // Directed: reset on the second beat of a frame from requester 2.
        @(negedge clk);
        reset         = 1'b0;
        mac_out_valid = 1'b0;
        req_valid     = 4'b0100;
        req_a[2*WA +: WA] = 12'h123;
        req_b[2*WB +: WB] = 8'h45;
        mac_a_ready   = 1'b1;
        mac_b_ready   = 1'b1;
        @(negedge clk);
        check("dir_grant2_ready", req_ready, 4'b0100);
        check("dir_grant2_data", mac_a_data, 12'h123);
        @(posedge clk);
        #1 req_a[2*WA +: WA] = 12'h456;
        #2 reset = 1'b1;
        #1;
        check("dir_async_busy", busy, 0);
        check("dir_async_ready", req_ready, 0);
        check("dir_async_valid", mac_a_valid, 0);
        check("dir_async_data", mac_a_data, 0);
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 4'b0101;
        req_a[0 +: WA] = 12'h00A;
        @(negedge clk);
        check("dir_post_rst_ready", req_ready, 4'b0001);
        check("dir_post_rst_data", mac_a_data, 12'h00A);

        // Randomized phase from a fresh reset.
        #1 reset  = 1'b1;
        req_valid = '0;
        mac_out_valid = 1'b0;
        model_init();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < CYCLES; c++) begin
            @(posedge clk);
            #1 drive_cycle();
            @(negedge clk);
            sample_cycle();
        end
        check("frames_progress", frames_done > 40, 1);
        check("pending_results", exp_q.size() <= 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
